mac_seq_ctrl: RTL and testbench

Sequencer for the MAC_unit dot-product datapath (4× signed-8 kernel × unsigned-8 image per 32-bit pair, fixed 3-cycle latency, no valid/enable of its own). Accepts a job of N operand pairs and issues them to the MAC via valid/ready. Tracks in-flight pairs with a valid shift register aligned to the MAC latency and accumulates every returned partial sum into a 32-bit result. Returns the result on a valid/ready port; sits between the CVA6 convolution issue logic and MAC_unit.

---
 rtl/mac_ctrl_pkg.sv | 15 +
 rtl/mac_vld_pipe.sv | 30 +++
 rtl/mac_seq_ctrl.sv | 137 +++++++++++++
 tb/tb_mac_seq_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_ctrl_pkg.sv
// Shared definitions for the MAC sequencer: FSM encoding and default sizing.
package mac_ctrl_pkg;

    localparam int XLEN_DEF        = 32;
    localparam int MAC_LATENCY_DEF = 3;
    localparam int LEN_W_DEF       = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/mac_vld_pipe.sv
// Valid shift register that mirrors the fixed MAC pipeline depth, so the
// output bit marks the cycle in which an issued pair's partial sum returns.
module mac_vld_pipe #(
    parameter int DEPTH = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] stages;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stages <= '0;
        end else if (clear) begin
            stages <= '0;
        end else begin
            stages[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign dout = stages[DEPTH-1];

endmodule

// File: rtl/mac_seq_ctrl.sv
// Sequencer that issues N operand pairs to the latency-fixed MAC datapath and
// accumulates the returned partial sums into one result word.
module mac_seq_ctrl
    import mac_ctrl_pkg::*;
#(
    parameter int XLEN        = XLEN_DEF,
    parameter int MAC_LATENCY = MAC_LATENCY_DEF,
    parameter int LEN_W       = LEN_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             abort_i,
    output logic             busy_o,
    input  logic             op_valid_i,
    output logic             op_ready_o,
    input  logic [XLEN-1:0]  kernel_i,
    input  logic [XLEN-1:0]  image_i,
    output logic [XLEN-1:0]  mac_a_o,
    output logic [XLEN-1:0]  mac_b_o,
    input  logic [XLEN-1:0]  mac_res_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [XLEN-1:0]  result_o
);

    state_t           state;
    state_t           state_next;
    logic [LEN_W-1:0] issue_cnt;
    logic [LEN_W-1:0] pend_cnt;
    logic [XLEN-1:0]  acc;
    logic [XLEN-1:0]  acc_sum;
    logic [XLEN-1:0]  result_q;
    logic             kill;
    logic             fire;
    logic             vld_out;
    logic             acc_en;
    logic             enter_done;

    // Abort only matters inside a job and wins over issue and accumulate.
    assign kill       = abort_i && (state != IDLE);
    assign fire       = (state == ISSUE) && op_valid_i && !abort_i;
    assign acc_en     = vld_out && !kill && ((state == ISSUE) || (state == DRAIN));
    assign acc_sum    = acc + mac_res_i;
    assign enter_done = (state_next == DONE) && (state != DONE);

    mac_vld_pipe #(
        .DEPTH (MAC_LATENCY)
    ) u_vld_pipe (
        .clk   (clk_i),
        .rst_n (rst_i),
        .clear (kill),
        .din   (fire),
        .dout  (vld_out)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_next = (len_i != '0) ? ISSUE : DONE;
                end
            end
            ISSUE: begin
                if (abort_i) begin
                    state_next = IDLE;
                end else if (fire && (issue_cnt == LEN_W'(1))) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (abort_i) begin
                    state_next = IDLE;
                end else if (acc_en && (pend_cnt == LEN_W'(1))) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (abort_i || res_ready_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy_o      = (state != IDLE);
        op_ready_o  = (state == ISSUE);
        res_valid_o = (state == DONE);
        mac_a_o     = fire ? kernel_i : '0;
        mac_b_o     = fire ? image_i  : '0;
    end

    // result_q is loaded only on entry to DONE so it survives the handshake and the next job start.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            issue_cnt <= '0;
            pend_cnt  <= '0;
            acc       <= '0;
            result_q  <= '0;
        end else if (kill) begin
            issue_cnt <= '0;
            pend_cnt  <= '0;
            acc       <= '0;
        end else begin
            if ((state == IDLE) && start_i) begin
                issue_cnt <= len_i;
                pend_cnt  <= len_i;
                acc       <= '0;
            end
            if (fire) begin
                issue_cnt <= issue_cnt - LEN_W'(1);
            end
            if (acc_en) begin
                acc      <= acc_sum;
                pend_cnt <= pend_cnt - LEN_W'(1);
            end
            if (enter_done) begin
                result_q <= (state == IDLE) ? '0 : acc_sum;
            end
        end
    end

    assign result_o = result_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Self-checking bench for mac_seq_ctrl with a behavioural 3-cycle MAC model.
module tb_mac_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  len;
    logic        abort;
    logic        busy;
    logic        op_valid;
    logic        op_ready;
    logic [31:0] kern;
    logic [31:0] img;
    logic [31:0] mac_a;
    logic [31:0] mac_b;
    logic [31:0] mac_res;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [31:0] p1 = '0;
    logic [31:0] p2 = '0;
    logic [31:0] p3 = '0;

    typedef struct {
        int          len;
        logic [31:0] kern;
        logic [31:0] img;
        int          gap;
        logic [31:0] exp_res;
        int          exp_lat;
    } vec_t;

    vec_t vecs[5];

    mac_seq_ctrl dut (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .start_i     (start),
        .len_i       (len),
        .abort_i     (abort),
        .busy_o      (busy),
        .op_valid_i  (op_valid),
        .op_ready_o  (op_ready),
        .kernel_i    (kern),
        .image_i     (img),
        .mac_a_o     (mac_a),
        .mac_b_o     (mac_b),
        .mac_res_i   (mac_res),
        .res_valid_o (res_valid),
        .res_ready_i (res_ready),
        .result_o    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Signed-kernel x unsigned-image 4-lane dot product, returned 3 cycles later.
    function automatic logic [31:0] dot4(input logic [31:0] a, input logic [31:0] b);
        int s;
        logic signed [7:0] ka;
        logic [7:0] ib;
        s = 0;
        for (int i = 0; i < 4; i++) begin
            ka = a[i*8 +: 8];
            ib = b[i*8 +: 8];
            s += int'(ka) * int'(ib);
        end
        return s;
    endfunction

    always @(posedge clk) begin
        p1 <= dot4(mac_a, mac_b);
        p2 <= p1;
        p3 <= p2;
    end
    assign mac_res = p3;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sampleEdge();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input vec_t v, input string tag);
        int first_fire;
        int waited;
        first_fire = 0;
        nextCycle();
        start = 1'b1;
        len   = 8'(v.len);
        nextCycle();
        start = 1'b0;
        for (int i = 0; i < v.len; i++) begin
            if (i > 0) begin
                for (int g = 0; g < v.gap; g++) begin
                    op_valid = 1'b0;
                    sampleEdge();
                    checkOutput({tag, " bubble ready"}, 32'(op_ready), 32'd1);
                    checkOutput({tag, " bubble mac_a"}, mac_a, 32'd0);
                    nextCycle();
                end
            end
            op_valid = 1'b1;
            kern     = v.kern;
            img      = v.img;
            sampleEdge();
            if (i == 0) first_fire = cyc;
            checkOutput({tag, " issue ready"}, 32'(op_ready), 32'd1);
            checkOutput({tag, " mac_a"}, mac_a, v.kern);
            checkOutput({tag, " mac_b"}, mac_b, v.img);
            nextCycle();
        end
        op_valid = 1'b0;
        kern     = '0;
        img      = '0;
        sampleEdge();
        checkOutput({tag, " drain ready"}, 32'(op_ready), 32'd0);
        checkOutput({tag, " drain busy"}, 32'(busy), 32'd1);
        waited = 0;
        while (res_valid !== 1'b1 && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        if (res_valid !== 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s timeout: res_valid got %b expected 1", tag, res_valid);
        end else begin
            checkOutput({tag, " result"}, result, v.exp_res);
            checkOutput({tag, " latency"}, 32'(cyc - first_fire), 32'(v.exp_lat));
            nextCycle();
            sampleEdge();
            checkOutput({tag, " post valid"}, 32'(res_valid), 32'd0);
            checkOutput({tag, " post busy"}, 32'(busy), 32'd0);
            checkOutput({tag, " post result"}, result, v.exp_res);
        end
    endtask

    initial begin
        start     = 1'b0;
        len       = '0;
        abort     = 1'b0;
        op_valid  = 1'b0;
        kern      = '0;
        img       = '0;
        res_ready = 1'b1;
        rst_n     = 1'b1;
        #2 rst_n  = 1'b0;
        repeat (3) @(posedge clk);
        sampleEdge();
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset ready", 32'(op_ready), 32'd0);
        checkOutput("reset valid", 32'(res_valid), 32'd0);
        checkOutput("reset result", result, 32'd0);
        checkOutput("reset mac_a", mac_a, 32'd0);
        nextCycle();
        rst_n = 1'b1;

        vecs[0] = '{3, 32'h01010101, 32'h02020202, 0, 32'h00000018, 6};
        vecs[1] = '{1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'hFFFFFC04, 4};
        vecs[2] = '{4, 32'h7F7F7F7F, 32'hFFFFFFFF, 2, 32'h0007E810, 13};
        vecs[3] = '{5, 32'h80808080, 32'hFFFFFFFF, 0, 32'hFFF60A00, 8};
        vecs[4] = '{2, 32'h03FE0102, 32'h10203040, 1, 32'h00000140, 6};
        for (int k = 0; k < 5; k++) begin
            applyStimulus(vecs[k], $sformatf("vec%0d", k));
        end

        // Zero-length job goes straight to DONE and must hold while unacknowledged.
        res_ready = 1'b0;
        nextCycle();
        start = 1'b1;
        len   = 8'd0;
        nextCycle();
        start = 1'b0;
        sampleEdge();
        checkOutput("len0 valid", 32'(res_valid), 32'd1);
        checkOutput("len0 result", result, 32'd0);
        checkOutput("len0 busy", 32'(busy), 32'd1);
        for (int i = 0; i < 5; i++) begin
            nextCycle();
            sampleEdge();
            checkOutput("len0 hold valid", 32'(res_valid), 32'd1);
            checkOutput("len0 hold result", result, 32'd0);
        end
        nextCycle();
        res_ready = 1'b1;
        sampleEdge();
        checkOutput("len0 hs valid", 32'(res_valid), 32'd1);
        nextCycle();
        sampleEdge();
        checkOutput("len0 idle valid", 32'(res_valid), 32'd0);
        checkOutput("len0 idle busy", 32'(busy), 32'd0);

        // Abort during DRAIN with two partial sums still in the MAC pipeline.
        nextCycle();
        start = 1'b1;
        len   = 8'd3;
        nextCycle();
        start    = 1'b0;
        op_valid = 1'b1;
        kern     = 32'h01010101;
        img      = 32'h02020202;
        repeat (3) nextCycle();
        op_valid = 1'b0;
        sampleEdge();
        checkOutput("abort drain ready", 32'(op_ready), 32'd0);
        nextCycle();
        abort = 1'b1;
        sampleEdge();
        checkOutput("abort cycle busy", 32'(busy), 32'd1);
        nextCycle();
        abort = 1'b0;
        sampleEdge();
        checkOutput("abort idle busy", 32'(busy), 32'd0);
        for (int i = 0; i < 6; i++) begin
            checkOutput("abort no valid", 32'(res_valid), 32'd0);
            checkOutput("abort result kept", result, 32'd0);
            nextCycle();
            sampleEdge();
        end
        applyStimulus('{1, 32'h01010101, 32'h02020202, 0, 32'h00000008, 4}, "after_abort");

        // Asynchronous reset in the middle of ISSUE.
        nextCycle();
        start = 1'b1;
        len   = 8'd4;
        nextCycle();
        start    = 1'b0;
        op_valid = 1'b1;
        kern     = 32'h7F7F7F7F;
        img      = 32'hFFFFFFFF;
        nextCycle();
        nextCycle();
        rst_n = 1'b0;
        #1;
        checkOutput("rst busy", 32'(busy), 32'd0);
        checkOutput("rst ready", 32'(op_ready), 32'd0);
        checkOutput("rst valid", 32'(res_valid), 32'd0);
        checkOutput("rst result", result, 32'd0);
        checkOutput("rst mac_a", mac_a, 32'd0);
        op_valid = 1'b0;
        nextCycle();
        rst_n = 1'b1;
        applyStimulus('{3, 32'h01010101, 32'h02020202, 0, 32'h00000018, 6}, "after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
